csr_access_arbiter: RTL and testbench
=====================================

// Module: csr_access_arbiter
// PURPOSE
//  Shares the single CSR module request/response port between two requesters: the executor (e) and the debug port (d).
//  Sits between the executor/dbg_port and csr in the River processor top.
//  - Allows one outstanding CSR transaction and routes the response back to its owner.
//  - Debug has priority; a streak limiter prevents executor starvation.
// PARAMETERS
//  ARCH        64                CSR data width (RISCV_ARCH)
//  REQTYPE_W   CsrReq_TotalBits  width of csr_req_type
//  DBG_STREAK  4                 max consecutive debug grants while executor is waiting (1..15)
// PORTS
//  i_clk             in   1          clock
//  i_nrst            in   1          reset, asynchronous, active-low
//  i_e_req_valid     in   1          executor request valid
//  o_e_req_ready     out  1          executor request accepted
//  i_e_req_type      in   REQTYPE_W  executor request type: [0] read, [1] write, [2] change mode
//  i_e_req_addr      in   12         executor CSR address
//  i_e_req_data      in   ARCH       executor CSR write data
//  o_e_resp_valid    out  1          response valid for executor
//  i_e_resp_ready    in   1          executor accepts response
//  i_d_req_*, o_d_req_ready, o_d_resp_valid, i_d_resp_ready   same set for debug port
//  o_req_valid       out  1          request to CSR module
//  i_req_ready       in   1          CSR module accepts request
//  o_req_type        out  REQTYPE_W  muxed request type
//  o_req_addr        out  12         muxed CSR address
//  o_req_data        out  ARCH       muxed write data
//  i_resp_valid      in   1          CSR module response valid
//  o_resp_ready      out  1          response accepted by owner (or drained)
//  i_resp_data       in   ARCH       CSR response data
//  i_resp_exception  in   1          CSR access exception
//  o_resp_data       out  ARCH       i_resp_data, shared; qualified by o_e/o_d_resp_valid
//  o_resp_exception  out  1          i_resp_exception, shared
//  o_stray_resp      out  1          1-cycle pulse: response received with no owner
// BEHAVIOUR
//  Reset values:
//  - state=IDLE, owner=NONE, streak=0, o_stray_resp=0.
//  - All valid/ready outputs are 0 except o_resp_ready=1 (IDLE drains).
//  - Data outputs are 0.
//  FSM IDLE:
//  - sel=D if i_d_req_valid and !(i_e_req_valid and streak==DBG_STREAK); else sel=E if i_e_req_valid.
//  - o_req_* = sel's fields, combinationally; o_req_valid=1 only if a requester is selected.
//  - o_x_req_ready = (sel==x) & i_req_ready. The unselected requester sees ready=0.
//  - Handshake (o_req_valid & i_req_ready) -> WAIT; owner<=sel.
//  - streak: +1 on a D grant while i_e_req_valid, else cleared to 0 on any E grant or a D grant with no E pending. Saturates at DBG_STREAK.
//  - o_resp_ready=1. An i_resp_valid in IDLE is discarded and pulses o_stray_resp the next cycle.
//  FSM WAIT:
//  - o_req_valid=0; both req_ready=0.
//  - o_owner_resp_valid=i_resp_valid; o_resp_ready=owner's resp_ready.
//  - On i_resp_valid & o_resp_ready -> IDLE, owner<=NONE.
//  - The next request may be granted in the following cycle (min 2 cycles between grants).
//  Requester rules:
//  - Requests hold valid and fields stable until accepted. The arbiter does not re-check this.
//  - A requester dropping valid before grant is not an error; selection re-evaluates every cycle.
//  Same-cycle events:
//  - Simultaneous e/d valid: the priority rule above applies.
//  - A response handshake and a new request in the same cycle: the new request waits until IDLE (no overlap).
//  Reset mid-transaction: returns to IDLE immediately. A late response is drained and flagged as o_stray_resp.
// TESTING
//  - Single E read, i_req_ready=1, response 2 cycles later -> o_e_resp_valid on that cycle, o_resp_data=csr value, owner=NONE after.
//  - E and D valid together, DBG_STREAK=4, D continuously valid -> grant order D,D,D,D,E,D...
//  - D response, i_d_resp_ready=0 for 3 cycles -> o_resp_ready=0, state stays WAIT; no grant until ready=1.
//  - i_nrst asserted in WAIT, then i_resp_valid -> no resp_valid to either requester; o_stray_resp=1 for 1 cycle.
//  - i_req_ready=0 with E pending for 5 cycles, then D arrives -> D granted first, E waits, streak=1.
//  - i_resp_exception=1 on an E write -> o_resp_exception=1 together with o_e_resp_valid.

Source files
------------

// File: rtl/csr_access_arbiter.sv
// Arbitrates the single CSR request/response port between the executor (e)
// and the debug port (d). One outstanding transaction; debug wins unless a streak limit is hit.
module csr_access_arbiter #(
  parameter int ARCH       = 64,
  parameter int REQTYPE_W  = 3,
  parameter int DBG_STREAK = 4
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  // executor
  input  logic                 i_e_req_valid,
  output logic                 o_e_req_ready,
  input  logic [REQTYPE_W-1:0] i_e_req_type,
  input  logic [11:0]          i_e_req_addr,
  input  logic [ARCH-1:0]      i_e_req_data,
  output logic                 o_e_resp_valid,
  input  logic                 i_e_resp_ready,
  // debug port
  input  logic                 i_d_req_valid,
  output logic                 o_d_req_ready,
  input  logic [REQTYPE_W-1:0] i_d_req_type,
  input  logic [11:0]          i_d_req_addr,
  input  logic [ARCH-1:0]      i_d_req_data,
  output logic                 o_d_resp_valid,
  input  logic                 i_d_resp_ready,
  // CSR module
  output logic                 o_req_valid,
  input  logic                 i_req_ready,
  output logic [REQTYPE_W-1:0] o_req_type,
  output logic [11:0]          o_req_addr,
  output logic [ARCH-1:0]      o_req_data,
  input  logic                 i_resp_valid,
  output logic                 o_resp_ready,
  input  logic [ARCH-1:0]      i_resp_data,
  input  logic                 i_resp_exception,
  output logic [ARCH-1:0]      o_resp_data,
  output logic                 o_resp_exception,
  output logic                 o_stray_resp
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_E, OWN_D} owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(DBG_STREAK);

  state_t     state, state_nxt;
  owner_t     owner, owner_nxt, sel;
  logic [3:0] streak, streak_nxt;
  logic       stray, stray_nxt;
  logic       resp_ready;

  // Debug yields only when the executor is waiting and debug has used up its streak.
  always_comb begin
    sel = OWN_NONE;
    if (i_d_req_valid && !(i_e_req_valid && streak == STREAK_MAX)) sel = OWN_D;
    else if (i_e_req_valid)                                        sel = OWN_E;
  end

  always_comb begin
    resp_ready = 1'b1;
    if (state == S_WAIT) begin
      case (owner)
        OWN_E:   resp_ready = i_e_resp_ready;
        OWN_D:   resp_ready = i_d_resp_ready;
        default: resp_ready = 1'b1;
      endcase
    end
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state  <= S_IDLE;
      owner  <= OWN_NONE;
      streak <= '0;
      stray  <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      streak <= streak_nxt;
      stray  <= stray_nxt;
    end
  end

  // Next-state logic
  // NOTE: every variable gets a default at the top of the block so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    streak_nxt = streak;
    stray_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        stray_nxt = i_resp_valid;
        if (sel != OWN_NONE && i_req_ready) begin
          state_nxt = S_WAIT;
          owner_nxt = sel;
          if (sel == OWN_D && i_e_req_valid)
            streak_nxt = (streak == STREAK_MAX) ? streak : streak + 4'd1;
          else
            streak_nxt = '0;
        end
      end
      S_WAIT: begin
        if (i_resp_valid && resp_ready) begin
          state_nxt = S_IDLE;
          owner_nxt = OWN_NONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_req_valid    = 1'b0;
    o_e_req_ready  = 1'b0;
    o_d_req_ready  = 1'b0;
    o_req_type     = '0;
    o_req_addr     = '0;
    o_req_data     = '0;
    o_e_resp_valid = 1'b0;
    o_d_resp_valid = 1'b0;
    if (state == S_IDLE) begin
      o_req_valid   = (sel != OWN_NONE);
      o_e_req_ready = (sel == OWN_E) && i_req_ready;
      o_d_req_ready = (sel == OWN_D) && i_req_ready;
      case (sel)
        OWN_E: begin
          o_req_type = i_e_req_type;
          o_req_addr = i_e_req_addr;
          o_req_data = i_e_req_data;
        end
        OWN_D: begin
          o_req_type = i_d_req_type;
          o_req_addr = i_d_req_addr;
          o_req_data = i_d_req_data;
        end
        default: ;
      endcase
    end else begin
      o_e_resp_valid = (owner == OWN_E) && i_resp_valid;
      o_d_resp_valid = (owner == OWN_D) && i_resp_valid;
    end
  end

  assign o_resp_ready     = resp_ready;
  assign o_resp_data      = i_resp_data;
  assign o_resp_exception = i_resp_exception;
  assign o_stray_resp     = stray;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Self-checking bench for csr_access_arbiter: directed scenarios plus a randomized
// run against a cycle-level reference model of the arbitration rules.
module tb_csr_access_arbiter;

  localparam int ARCH = 64;
  localparam int RTW  = 3;
  localparam int LIM  = 4;

  logic            i_clk = 1'b0;
  logic            i_nrst;
  logic            i_e_req_valid, o_e_req_ready, o_e_resp_valid, i_e_resp_ready;
  logic [RTW-1:0]  i_e_req_type;
  logic [11:0]     i_e_req_addr;
  logic [ARCH-1:0] i_e_req_data;
  logic            i_d_req_valid, o_d_req_ready, o_d_resp_valid, i_d_resp_ready;
  logic [RTW-1:0]  i_d_req_type;
  logic [11:0]     i_d_req_addr;
  logic [ARCH-1:0] i_d_req_data;
  logic            o_req_valid, i_req_ready;
  logic [RTW-1:0]  o_req_type;
  logic [11:0]     o_req_addr;
  logic [ARCH-1:0] o_req_data;
  logic            i_resp_valid, o_resp_ready, i_resp_exception, o_resp_exception, o_stray_resp;
  logic [ARCH-1:0] i_resp_data, o_resp_data;

  int compared = 0;
  int failed   = 0;

  always #5 i_clk = ~i_clk;

  csr_access_arbiter #(.ARCH(ARCH), .REQTYPE_W(RTW), .DBG_STREAK(LIM)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_e_req_valid(i_e_req_valid), .o_e_req_ready(o_e_req_ready), .i_e_req_type(i_e_req_type),
    .i_e_req_addr(i_e_req_addr), .i_e_req_data(i_e_req_data), .o_e_resp_valid(o_e_resp_valid),
    .i_e_resp_ready(i_e_resp_ready),
    .i_d_req_valid(i_d_req_valid), .o_d_req_ready(o_d_req_ready), .i_d_req_type(i_d_req_type),
    .i_d_req_addr(i_d_req_addr), .i_d_req_data(i_d_req_data), .o_d_resp_valid(o_d_resp_valid),
    .i_d_resp_ready(i_d_resp_ready),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_type(o_req_type),
    .o_req_addr(o_req_addr), .o_req_data(o_req_data),
    .i_resp_valid(i_resp_valid), .o_resp_ready(o_resp_ready), .i_resp_data(i_resp_data),
    .i_resp_exception(i_resp_exception), .o_resp_data(o_resp_data),
    .o_resp_exception(o_resp_exception), .o_stray_resp(o_stray_resp)
  );

  task automatic clear_inputs();
    i_e_req_valid = 0; i_e_req_type = '0; i_e_req_addr = '0; i_e_req_data = '0; i_e_resp_ready = 0;
    i_d_req_valid = 0; i_d_req_type = '0; i_d_req_addr = '0; i_d_req_data = '0; i_d_resp_ready = 0;
    i_req_ready = 0; i_resp_valid = 0; i_resp_data = '0; i_resp_exception = 0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    clear_inputs();
    i_nrst = 1'b0;
    @(negedge i_clk);
    i_nrst = 1'b1;
  endtask

  // Drives both requesters continuously with an always-ready CSR and records who is granted
  // (1 = executor, 2 = debug) for up to n grants within a bounded number of cycles.
  task automatic collect_grants(input int n, output int order[16]);
    int k = 0;
    for (int i = 0; i < 16; i++) order[i] = 0;
    for (int cyc = 0; cyc < 4 * n && k < n; cyc++) begin
      @(negedge i_clk);
      i_e_req_valid = 1; i_d_req_valid = 1; i_req_ready = 1;
      i_resp_valid = 1; i_e_resp_ready = 1; i_d_resp_ready = 1;
      #1;
      if (o_req_valid && o_e_req_ready)      begin order[k] = 1; k++; end
      else if (o_req_valid && o_d_req_ready) begin order[k] = 2; k++; end
    end
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    clear_inputs();
    i_nrst = 1'b0;
    #1;
    compared++;
    if ({o_req_valid, o_e_req_ready, o_d_req_ready, o_e_resp_valid, o_d_resp_valid,
         o_resp_ready, o_stray_resp} !== 7'b0000010) begin
      failed++;
      $display("FAIL reset_ctl got=%b exp=0000010", {o_req_valid, o_e_req_ready, o_d_req_ready,
               o_e_resp_valid, o_d_resp_valid, o_resp_ready, o_stray_resp});
    end
    compared++;
    if ({o_req_type, o_req_addr, o_req_data} !== '0) begin
      failed++;
      $display("FAIL reset_data got=%h exp=0", {o_req_type, o_req_addr, o_req_data});
    end
    @(negedge i_clk);
    i_nrst = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge i_clk);
    i_e_req_valid = 1; i_e_req_type = 3'b001; i_e_req_addr = 12'h300;
    i_e_req_data = 64'h1111; i_req_ready = 1;
    #1;
    compared++;
    if ({o_req_valid, o_e_req_ready, o_d_req_ready, o_req_addr, o_req_type} !== {3'b110, 12'h300, 3'b001}) begin
      failed++;
      $display("FAIL single_req got=%b/%h/%b", {o_req_valid, o_e_req_ready, o_d_req_ready}, o_req_addr, o_req_type);
    end
    @(negedge i_clk);
    i_e_req_valid = 0;
    #1;
    compared++;
    if ({o_req_valid, o_e_resp_valid} !== 2'b00) begin
      failed++;
      $display("FAIL single_wait got=%b exp=00", {o_req_valid, o_e_resp_valid});
    end
    @(negedge i_clk);
    i_resp_valid = 1; i_resp_data = 64'hDEAD_BEEF_0123_4567; i_e_resp_ready = 1;
    #1;
    compared++;
    if ({o_e_resp_valid, o_d_resp_valid, o_resp_ready} !== 3'b101 || o_resp_data !== 64'hDEAD_BEEF_0123_4567) begin
      failed++;
      $display("FAIL single_resp got=%b data=%h exp=101 data=deadbeef01234567",
               {o_e_resp_valid, o_d_resp_valid, o_resp_ready}, o_resp_data);
    end
    // owner must be NONE now: a further response is not routed and is flagged as stray
    @(negedge i_clk);
    #1;
    compared++;
    if ({o_e_resp_valid, o_d_resp_valid, o_resp_ready, o_stray_resp} !== 4'b0010) begin
      failed++;
      $display("FAIL single_after got=%b exp=0010", {o_e_resp_valid, o_d_resp_valid, o_resp_ready, o_stray_resp});
    end
    @(negedge i_clk);
    i_resp_valid = 0;
    #1;
    compared++;
    if (o_stray_resp !== 1'b1) begin
      failed++;
      $display("FAIL single_stray got=%b exp=1", o_stray_resp);
    end
  endtask

  task automatic test_streak();
    int order[16];
    int exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    do_reset();
    collect_grants(10, order);
    for (int i = 0; i < 10; i++) begin
      compared++;
      if (order[i] !== exp_order[i]) begin
        failed++;
        $display("FAIL streak_grant[%0d] got=%0d exp=%0d", i, order[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge i_clk);
    i_d_req_valid = 1; i_d_req_addr = 12'h7B0; i_req_ready = 1;
    #1;
    compared++;
    if ({o_d_req_ready, o_e_req_ready} !== 2'b10) begin
      failed++;
      $display("FAIL bp_grant got=%b exp=10", {o_d_req_ready, o_e_req_ready});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      i_d_req_valid = 0; i_e_req_valid = 1; i_resp_valid = 1; i_d_resp_ready = 0;
      #1;
      compared++;
      if ({o_resp_ready, o_d_resp_valid, o_req_valid, o_e_req_ready} !== 4'b0100) begin
        failed++;
        $display("FAIL bp_hold[%0d] got=%b exp=0100", i, {o_resp_ready, o_d_resp_valid, o_req_valid, o_e_req_ready});
      end
    end
    @(negedge i_clk);
    i_d_resp_ready = 1;
    #1;
    compared++;
    if ({o_resp_ready, o_d_resp_valid, o_req_valid} !== 3'b110) begin
      failed++;
      $display("FAIL bp_release got=%b exp=110", {o_resp_ready, o_d_resp_valid, o_req_valid});
    end
    @(negedge i_clk);
    i_resp_valid = 0;
    #1;
    compared++;
    if ({o_req_valid, o_e_req_ready} !== 2'b11) begin
      failed++;
      $display("FAIL bp_next_grant got=%b exp=11", {o_req_valid, o_e_req_ready});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge i_clk);
    i_e_req_valid = 1; i_req_ready = 1;
    @(negedge i_clk);
    i_e_req_valid = 0; i_e_resp_ready = 1;
    i_nrst = 0;
    #1;
    compared++;
    if ({o_resp_ready, o_e_resp_valid} !== 2'b10) begin
      failed++;
      $display("FAIL rstmid_idle got=%b exp=10", {o_resp_ready, o_e_resp_valid});
    end
    @(negedge i_clk);
    i_nrst = 1; i_resp_valid = 1; i_resp_data = 64'h55;
    #1;
    compared++;
    if ({o_e_resp_valid, o_d_resp_valid, o_resp_ready, o_stray_resp} !== 4'b0010) begin
      failed++;
      $display("FAIL rstmid_late got=%b exp=0010", {o_e_resp_valid, o_d_resp_valid, o_resp_ready, o_stray_resp});
    end
    @(negedge i_clk);
    i_resp_valid = 0;
    #1;
    compared++;
    if (o_stray_resp !== 1'b1) begin
      failed++;
      $display("FAIL rstmid_stray got=%b exp=1", o_stray_resp);
    end
    @(negedge i_clk);
    #1;
    compared++;
    if (o_stray_resp !== 1'b0) begin
      failed++;
      $display("FAIL rstmid_stray_pulse got=%b exp=0", o_stray_resp);
    end
  endtask

  task automatic test_ready_low();
    int order[16];
    int exp_order[4] = '{2, 2, 2, 1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      i_e_req_valid = 1; i_e_req_addr = 12'h111; i_req_ready = 0;
      #1;
      compared++;
      if ({o_req_valid, o_e_req_ready, o_req_addr} !== {2'b10, 12'h111}) begin
        failed++;
        $display("FAIL rdylow_e[%0d] got=%b addr=%h", i, {o_req_valid, o_e_req_ready}, o_req_addr);
      end
    end
    @(negedge i_clk);
    i_d_req_valid = 1; i_d_req_addr = 12'h222;
    #1;
    compared++;
    if ({o_req_valid, o_d_req_ready, o_req_addr} !== {2'b10, 12'h222}) begin
      failed++;
      $display("FAIL rdylow_dsel got=%b addr=%h", {o_req_valid, o_d_req_ready}, o_req_addr);
    end
    @(negedge i_clk);
    i_req_ready = 1;
    #1;
    compared++;
    if ({o_d_req_ready, o_e_req_ready} !== 2'b10) begin
      failed++;
      $display("FAIL rdylow_dgrant got=%b exp=10", {o_d_req_ready, o_e_req_ready});
    end
    // streak is now 1, so three more debug grants fit before the executor gets in
    collect_grants(4, order);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (order[i] !== exp_order[i]) begin
        failed++;
        $display("FAIL rdylow_streak[%0d] got=%0d exp=%0d", i, order[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_exception();
    do_reset();
    @(negedge i_clk);
    i_e_req_valid = 1; i_e_req_type = 3'b010; i_e_req_addr = 12'hF14; i_req_ready = 1;
    @(negedge i_clk);
    i_e_req_valid = 0; i_resp_valid = 1; i_resp_exception = 1; i_e_resp_ready = 1;
    #1;
    compared++;
    if ({o_e_resp_valid, o_resp_exception} !== 2'b11) begin
      failed++;
      $display("FAIL exc got=%b exp=11", {o_e_resp_valid, o_resp_exception});
    end
  endtask

  // Reference model state: busy flag, owner (0 none / 1 e / 2 d), streak count, stray pulse.
  task automatic test_random();
    bit m_busy = 0;
    int m_owner = 0, m_streak = 0;
    bit m_stray = 0;
    int sel;
    logic [6:0] exp_ctl, got_ctl;
    logic [RTW+12+ARCH-1:0] exp_req;
    bit m_rready;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge i_clk);
      i_e_req_valid  = ($urandom_range(0, 9) < 6);
      i_d_req_valid  = ($urandom_range(0, 9) < 5);
      i_req_ready    = ($urandom_range(0, 9) < 7);
      i_resp_valid   = ($urandom_range(0, 9) < 5);
      i_e_resp_ready = ($urandom_range(0, 9) < 7);
      i_d_resp_ready = ($urandom_range(0, 9) < 7);
      i_e_req_type = RTW'($urandom); i_e_req_addr = 12'($urandom); i_e_req_data = {$urandom, $urandom};
      i_d_req_type = RTW'($urandom); i_d_req_addr = 12'($urandom); i_d_req_data = {$urandom, $urandom};
      i_resp_data = {$urandom, $urandom}; i_resp_exception = 1'($urandom);

      sel = 0;
      if (!m_busy) begin
        if (i_d_req_valid && !(i_e_req_valid && m_streak == LIM)) sel = 2;
        else if (i_e_req_valid) sel = 1;
      end
      m_rready = !m_busy ? 1'b1 : (m_owner == 1 ? i_e_resp_ready : i_d_resp_ready);
      exp_ctl = {sel != 0, sel == 1 && i_req_ready, sel == 2 && i_req_ready,
                 m_busy && m_owner == 1 && i_resp_valid, m_busy && m_owner == 2 && i_resp_valid,
                 m_rready, m_stray};
      exp_req = (sel == 1) ? {i_e_req_type, i_e_req_addr, i_e_req_data} :
                (sel == 2) ? {i_d_req_type, i_d_req_addr, i_d_req_data} : '0;
      #1;
      got_ctl = {o_req_valid, o_e_req_ready, o_d_req_ready, o_e_resp_valid, o_d_resp_valid,
                 o_resp_ready, o_stray_resp};
      compared++;
      if (got_ctl !== exp_ctl) begin
        failed++;
        $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", cyc, got_ctl, exp_ctl);
      end
      compared++;
      if ({o_req_type, o_req_addr, o_req_data} !== exp_req) begin
        failed++;
        $display("FAIL rnd_req cyc=%0d got=%h exp=%h", cyc, {o_req_type, o_req_addr, o_req_data}, exp_req);
      end
      compared++;
      if ({o_resp_exception, o_resp_data} !== {i_resp_exception, i_resp_data}) begin
        failed++;
        $display("FAIL rnd_resp cyc=%0d got=%h exp=%h", cyc, {o_resp_exception, o_resp_data},
                 {i_resp_exception, i_resp_data});
      end

      @(posedge i_clk);
      if (!m_busy) begin
        m_stray = i_resp_valid;
        if (sel != 0 && i_req_ready) begin
          m_busy = 1; m_owner = sel;
          m_streak = (sel == 2 && i_e_req_valid) ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
        end
      end else begin
        m_stray = 0;
        if (i_resp_valid && m_rready) begin
          m_busy = 0; m_owner = 0;
        end
      end
    end
  endtask

  initial begin
    clear_inputs();
    i_nrst = 1'b0;
    test_reset();
    test_single_read();
    test_streak();
    test_backpressure();
    test_reset_mid();
    test_ready_low();
    test_exception();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
